// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operation driver:
//   - operand / result / op-select widths
//   - op-select constants driven onto the ALU mux select input
//   - FSM state encoding of the command sequencer
// ----------------------------------------------------------------------------
package alu_pkg;

   localparam int A_W   = 4;                 // operand width
   localparam int Y_W   = 8;                 // result width
   localparam int OP_W  = 2;                 // op-select width
   localparam int CMD_W = OP_W + 2 * A_W;    // FIFO entry {op,a,b}

   localparam logic [OP_W-1:0] OP_CONC = 2'b00;  // {a,b}
   localparam logic [OP_W-1:0] OP_ADD  = 2'b01;  // a + b
   localparam logic [OP_W-1:0] OP_SHL  = 2'b10;  // a << b[1:0]
   localparam logic [OP_W-1:0] OP_MUL  = 2'b11;  // a * b

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } drv_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// ----------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous command FIFO holding {op,a,b} entries in strict arrival order.
// Pushes while full and pops while empty are ignored. Storage is not reset;
// only pointers and the occupancy count are.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   i_push   in   push request (ignored when full)
//   i_pop    in   pop request (ignored when empty)
//   i_data   in   entry to push
//   o_data   out  entry at the head (valid when not empty)
//   o_full   out  FIFO holds DEPTH entries
//   o_empty  out  FIFO holds no entries
//   o_count  out  current occupancy
// ----------------------------------------------------------------------------
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = CMD_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [W-1:0]             i_data,
   output logic [W-1:0]             o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/alu_op_driver.sv
// ----------------------------------------------------------------------------
// alu_op_driver
// Command-side sequencer for the 4-bit ALU mux. Commands are queued in a
// FIFO, popped one at a time, driven onto alu_a/alu_b/alu_s, allowed to
// settle for SETTLE cycles, and the sampled alu_y is returned over the
// response handshake together with the op that produced it.
//
// Optional feature macro: ALU_DRV_CHECK_EN
//   defined   : an inline reference model checks alu_y at every capture and
//               sets the sticky err flag on a mismatch (cleared only by rst)
//   undefined : no model logic; err is tied to 0
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  FIFO can accept a command (not full)
//   cmd_a      in   operand A
//   cmd_b      in   operand B
//   cmd_op     in   operation select
//   alu_a      out  to ALU a
//   alu_b      out  to ALU b
//   alu_s      out  to ALU S
//   alu_y      in   from ALU Y
//   rsp_valid  out  result held
//   rsp_ready  in   consumer accepts result
//   rsp_y      out  captured result
//   rsp_op     out  op that produced rsp_y
//   busy       out  FIFO non-empty or sequencer not idle
//   err        out  sticky result-mismatch flag
// ----------------------------------------------------------------------------
module alu_op_driver
   import alu_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [A_W-1:0]   cmd_a,
   input  logic [A_W-1:0]   cmd_b,
   input  logic [OP_W-1:0]  cmd_op,
   output logic [A_W-1:0]   alu_a,
   output logic [A_W-1:0]   alu_b,
   output logic [OP_W-1:0]  alu_s,
   input  logic [Y_W-1:0]   alu_y,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [Y_W-1:0]   rsp_y,
   output logic [OP_W-1:0]  rsp_op,
   output logic             busy,
   output logic             err
);

   localparam int CNT_W = $clog2(SETTLE + 1);

   drv_state_e             r_state;
   drv_state_e             w_next;
   logic                   w_pop;
   logic                   w_cap;
   logic                   w_rsp_done;
   logic [CMD_W-1:0]       w_fifo_data;
   logic                   w_full;
   logic                   w_empty;
   logic [$clog2(DEPTH):0] w_count;
   logic [CNT_W-1:0]       r_cnt;
   logic [A_W-1:0]         r_alu_a;
   logic [A_W-1:0]         r_alu_b;
   logic [OP_W-1:0]        r_alu_s;
   logic                   r_rsp_valid;
   logic [Y_W-1:0]         r_rsp_y;
   logic [OP_W-1:0]        r_rsp_op;

   alu_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (CMD_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (cmd_valid),
      .i_pop   (w_pop),
      .i_data  ({cmd_op, cmd_a, cmd_b}),
      .o_data  (w_fifo_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign cmd_ready = !w_full;
   assign busy      = (w_count != '0) || (r_state != ST_IDLE);
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_s     = r_alu_s;
   assign rsp_valid = r_rsp_valid;
   assign rsp_y     = r_rsp_y;
   assign rsp_op    = r_rsp_op;

   // Next-state and per-edge strobes. The settle counter is loaded with
   // SETTLE on a pop, so capture happens on the edge where it steps 1 -> 0.
   always_comb begin
      w_next     = r_state;
      w_pop      = 1'b0;
      w_cap      = 1'b0;
      w_rsp_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               w_pop  = 1'b1;
               w_next = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (r_cnt == CNT_W'(1)) begin
               w_cap  = 1'b1;
               w_next = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_rsp_done = 1'b1;
               if (!w_empty) begin
                  w_pop  = 1'b1;
                  w_next = ST_SETTLE;
               end else begin
                  w_next = ST_IDLE;
               end
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_s     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_y     <= '0;
         r_rsp_op    <= '0;
      end else begin
         r_state <= w_next;
         if (w_pop) begin
            r_alu_s <= w_fifo_data[CMD_W-1 -: OP_W];
            r_alu_a <= w_fifo_data[2*A_W-1 -: A_W];
            r_alu_b <= w_fifo_data[A_W-1:0];
            r_cnt   <= CNT_W'(SETTLE);
         end else if (r_state == ST_SETTLE) begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
         if (w_cap) begin
            r_rsp_valid <= 1'b1;
            r_rsp_y     <= alu_y;
            r_rsp_op    <= r_alu_s;
         end else if (w_rsp_done) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

`ifdef ALU_DRV_CHECK_EN
   logic r_err;

   function automatic logic [Y_W-1:0] f_alu_ref(input logic [A_W-1:0]  a,
                                                input logic [A_W-1:0]  b,
                                                input logic [OP_W-1:0] s);
      logic [Y_W-1:0] ea;
      logic [Y_W-1:0] eb;
      ea = {{(Y_W-A_W){1'b0}}, a};
      eb = {{(Y_W-A_W){1'b0}}, b};
      case (s)
         OP_CONC: f_alu_ref = {a, b};
         OP_ADD:  f_alu_ref = ea + eb;
         OP_SHL:  f_alu_ref = ea << b[1:0];
         default: f_alu_ref = ea * eb;
      endcase
   endfunction

   // Sticky: once set, only rst clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_cap && (alu_y != f_alu_ref(r_alu_a, r_alu_b, r_alu_s))) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_driver.sv
module tb_alu_op_driver;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_a, cmd_b;
   logic [1:0] cmd_op;
   logic [3:0] alu_a, alu_b;
   logic [1:0] alu_s;
   logic [7:0] alu_y;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_y;
   logic [1:0] rsp_op;
   logic       busy, err;
   logic       force_zero;

   // second instance with a longer settle time
   logic       rst3, c3_valid, c3_ready;
   logic [3:0] c3_a, c3_b;
   logic [1:0] c3_op;
   logic [3:0] alu_a3, alu_b3;
   logic [1:0] alu_s3;
   logic [7:0] alu_y3;
   logic       rsp_valid3, rsp_ready3;
   logic [7:0] rsp_y3;
   logic [1:0] rsp_op3;
   logic       busy3, err3;

   localparam int SETTLE3 = 3;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int push_to = 0;
   int exp_y[$];
   int exp_op[$];
   int got_y[$];
   int got_op[$];
   int got_cyc[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural ALU: plain integer arithmetic on the operation rules
   function automatic int ref_y(input int a, input int b, input int op);
      case (op)
         0: return a * 16 + b;
         1: return a + b;
         2: return a * (1 << (b % 4));
         default: return a * b;
      endcase
   endfunction

   assign alu_y  = force_zero ? 8'h00 : 8'(ref_y(int'(alu_a), int'(alu_b), int'(alu_s)));
   assign alu_y3 = 8'(ref_y(int'(alu_a3), int'(alu_b3), int'(alu_s3)));

   alu_op_driver #(.DEPTH(4), .SETTLE(1)) u_dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
      .rsp_op(rsp_op), .busy(busy), .err(err)
   );

   alu_op_driver #(.DEPTH(4), .SETTLE(SETTLE3)) u_dut3 (
      .clk(clk), .rst(rst3), .cmd_valid(c3_valid), .cmd_ready(c3_ready),
      .cmd_a(c3_a), .cmd_b(c3_b), .cmd_op(c3_op),
      .alu_a(alu_a3), .alu_b(alu_b3), .alu_s(alu_s3), .alu_y(alu_y3),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_y(rsp_y3),
      .rsp_op(rsp_op3), .busy(busy3), .err(err3)
   );

   // Driver: offers one command, waits (bounded) for acceptance, records it
   task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
      int k = 0;
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
      while (!cmd_ready && k < 500) begin
         @(posedge clk); #1; k++;
      end
      if (!cmd_ready) push_to++;
      else begin
         exp_y.push_back(ref_y(int'(a), int'(b), int'(op)));
         exp_op.push_back(int'(op));
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   // Receiver: records responses consumed at each edge; no comparisons here
   task automatic collect(input int n, input int budget, input bit rand_ready);
      int k = 0;
      got_y.delete(); got_op.delete(); got_cyc.delete();
      while (got_y.size() < n && k < budget) begin
         if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
         if (rsp_valid && rsp_ready) begin
            got_y.push_back(int'(rsp_y));
            got_op.push_back(int'(rsp_op));
            got_cyc.push_back(cyc);
         end
         @(posedge clk); #1; k++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; rst3 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; rst3 = 1'b0;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
      checks++; if ({alu_a, alu_b, alu_s} !== 10'd0) begin errors++; $display("FAIL reset_alu got %h exp 0", {alu_a, alu_b, alu_s}); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
      checks++; if ({rsp_y, rsp_op} !== 10'd0) begin errors++; $display("FAIL reset_rsp got %h exp 0", {rsp_y, rsp_op}); end
      checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_busy_err got %b%b exp 00", busy, err); end
      checks++; if (busy3 !== 1'b0 || rsp_valid3 !== 1'b0 || c3_ready !== 1'b1) begin
         errors++; $display("FAIL reset_inst3 got busy=%b vld=%b rdy=%b exp 0 0 1", busy3, rsp_valid3, c3_ready); end
   endtask

   task automatic test_ops_basic();
      int tbl[4] = '{8'h35, 8'h08, 8'h06, 8'h0F};
      exp_y.delete(); exp_op.delete(); push_to = 0;
      rsp_ready = 1'b1;
      fork
         for (int i = 0; i < 4; i++) push_cmd(4'h3, 4'h5, 2'(i));
         collect(4, 100, 1'b0);
      join
      checks++; if (got_y.size() != 4 || push_to != 0) begin errors++; $display("FAIL basic_count got %0d exp 4 (timeouts %0d)", got_y.size(), push_to); end
      for (int i = 0; i < got_y.size(); i++) begin
         checks++; if (got_y[i] != tbl[i]) begin errors++; $display("FAIL basic_y[%0d] got %h exp %h", i, got_y[i], tbl[i]); end
         checks++; if (got_op[i] != i) begin errors++; $display("FAIL basic_op[%0d] got %0d exp %0d", i, got_op[i], i); end
      end
      for (int i = 1; i < got_cyc.size(); i++) begin
         checks++; if (got_cyc[i] - got_cyc[i-1] != 2) begin errors++; $display("FAIL basic_throughput[%0d] got %0d exp 2", i, got_cyc[i] - got_cyc[i-1]); end
      end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", err); end
   endtask

   task automatic test_ops_max();
      int tbl[4] = '{8'hFF, 8'h1E, 8'h78, 8'hE1};
      exp_y.delete(); exp_op.delete(); push_to = 0;
      rsp_ready = 1'b1;
      fork
         for (int i = 0; i < 4; i++) push_cmd(4'hF, 4'hF, 2'(i));
         collect(4, 100, 1'b0);
      join
      checks++; if (got_y.size() != 4 || push_to != 0) begin errors++; $display("FAIL max_count got %0d exp 4", got_y.size()); end
      for (int i = 0; i < got_y.size(); i++) begin
         checks++; if (got_y[i] != tbl[i]) begin errors++; $display("FAIL max_y[%0d] got %h exp %h", i, got_y[i], tbl[i]); end
      end
   endtask

   task automatic test_random();
      int n = 40;
      exp_y.delete(); exp_op.delete(); push_to = 0;
      fork
         for (int i = 0; i < n; i++) begin
            push_cmd(4'($urandom), 4'($urandom), 2'($urandom));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
         collect(n, 3000, 1'b1);
      join
      rsp_ready = 1'b1;
      checks++; if (got_y.size() != n || exp_y.size() != n) begin
         errors++; $display("FAIL rand_count got %0d exp %0d", got_y.size(), exp_y.size()); end
      for (int i = 0; i < got_y.size() && i < exp_y.size(); i++) begin
         checks++; if (got_y[i] != exp_y[i] || got_op[i] != exp_op[i]) begin
            errors++; $display("FAIL rand[%0d] got y=%h op=%0d exp y=%h op=%0d", i, got_y[i], got_op[i], exp_y[i], exp_op[i]); end
      end
   endtask

   task automatic test_back_to_back_full();
      int acc = 0;
      exp_y.delete(); exp_op.delete();
      rsp_ready = 1'b0;
      cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 2'($urandom);
      cmd_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (cmd_ready) begin
            acc++;
            exp_y.push_back(ref_y(int'(cmd_a), int'(cmd_b), int'(cmd_op)));
            exp_op.push_back(int'(cmd_op));
            @(posedge clk); #1;
            cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 2'($urandom);
         end else begin
            @(posedge clk); #1;
         end
      end
      checks++; if (acc != 5) begin errors++; $display("FAIL full_accepts got %0d exp 5", acc); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_cmd_ready got %b exp 0", cmd_ready); end
      checks++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL full_hold got vld=%b busy=%b exp 1 1", rsp_valid, busy); end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      collect(5, 200, 1'b0);
      checks++; if (got_y.size() != 5) begin errors++; $display("FAIL full_drain_count got %0d exp 5", got_y.size()); end
      for (int i = 0; i < got_y.size() && i < exp_y.size(); i++) begin
         checks++; if (got_y[i] != exp_y[i] || got_op[i] != exp_op[i]) begin
            errors++; $display("FAIL full_drain[%0d] got y=%h op=%0d exp y=%h op=%0d", i, got_y[i], got_op[i], exp_y[i], exp_op[i]); end
      end
      repeat (3) begin @(posedge clk); #1; end
      checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL full_idle got busy=%b rdy=%b exp 0 1", busy, cmd_ready); end
   endtask

   task automatic test_settle3();
      logic [3:0] a = 4'h9, b = 4'h6;
      logic [1:0] op = 2'b11;
      int first = -1;
      bit stable = 1'b1;
      rsp_ready3 = 1'b0;
      c3_a = a; c3_b = b; c3_op = op; c3_valid = 1'b1;
      @(posedge clk); #1;
      c3_valid = 1'b0;
      for (int i = 1; i <= 20 && first < 0; i++) begin
         @(posedge clk); #1;
         if (alu_a3 !== a || alu_b3 !== b || alu_s3 !== op) stable = 1'b0;
         if (rsp_valid3) first = i;
      end
      checks++; if (first != 1 + SETTLE3) begin errors++; $display("FAIL s3_latency got %0d exp %0d", first, 1 + SETTLE3); end
      checks++; if (!stable) begin errors++; $display("FAIL s3_alu_stable got unstable exp stable"); end
      checks++; if (int'(rsp_y3) != ref_y(9, 6, 3) || rsp_op3 !== op) begin
         errors++; $display("FAIL s3_result got %h/%0d exp %h/%0d", rsp_y3, rsp_op3, ref_y(9, 6, 3), op); end
      rsp_ready3 = 1'b1;
      @(posedge clk); #1;
      checks++; if (rsp_valid3 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL s3_done got vld=%b busy=%b exp 0 0", rsp_valid3, busy3); end
      checks++; if (alu_a3 !== a || alu_b3 !== b || alu_s3 !== op) begin
         errors++; $display("FAIL s3_alu_hold got %h%h%h exp %h%h%h", alu_a3, alu_b3, alu_s3, a, b, op); end
   endtask

   task automatic test_reset_mid();
      bit stale = 1'b0;
      rsp_ready3 = 1'b0;
      c3_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         c3_a = 4'(i + 2); c3_b = 4'(i + 7); c3_op = 2'(i);
         @(posedge clk); #1;
      end
      c3_valid = 1'b0;
      checks++; if (busy3 !== 1'b1 || rsp_valid3 !== 1'b0) begin errors++; $display("FAIL mid_pre got busy=%b vld=%b exp 1 0", busy3, rsp_valid3); end
      rst3 = 1'b1;
      @(posedge clk); #1;
      rst3 = 1'b0;
      checks++; if (rsp_valid3 !== 1'b0 || busy3 !== 1'b0 || c3_ready !== 1'b1) begin
         errors++; $display("FAIL mid_rst got vld=%b busy=%b rdy=%b exp 0 0 1", rsp_valid3, busy3, c3_ready); end
      checks++; if ({alu_a3, alu_b3, alu_s3} !== 10'd0) begin errors++; $display("FAIL mid_rst_alu got %h exp 0", {alu_a3, alu_b3, alu_s3}); end
      rsp_ready3 = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (rsp_valid3 || busy3) stale = 1'b1;
      end
      checks++; if (stale) begin errors++; $display("FAIL mid_stale got activity exp none"); end
   endtask

`ifdef ALU_DRV_CHECK_EN
   task automatic test_err();
      exp_y.delete(); exp_op.delete();
      rsp_ready = 1'b1;
      force_zero = 1'b1;
      fork
         push_cmd(4'h1, 4'h1, 2'b01);
         collect(1, 50, 1'b0);
      join
      force_zero = 1'b0;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", err); end
      fork
         push_cmd(4'h2, 4'h3, 2'b01);
         collect(1, 50, 1'b0);
      join
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err); end
   endtask
`endif

   initial begin
      cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_op = 0; rsp_ready = 0; force_zero = 0;
      c3_valid = 0; c3_a = 0; c3_b = 0; c3_op = 0; rsp_ready3 = 0;
      rst = 1; rst3 = 1;
      test_reset();
      test_ops_basic();
      test_ops_max();
      test_random();
      test_back_to_back_full();
      test_settle3();
      test_reset_mid();
`ifdef ALU_DRV_CHECK_EN
      test_err();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
